arm_mc_controller: RTL

- Multicycle control unit for the ARM datapath: sequences fetch, decode, execute, memory and writeback over several clocks.
- Drives the immediate-extender select, ALU/mux selects and all write strobes.
- Holds the NZCV condition-flag register and evaluates the condition field.
- Sits between the instruction register and the shared datapath (register file, ALU, extender, unified memory).

---
 rtl/arm_mc_controller_if.sv | 33 +++
 rtl/arm_mc_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller_if.sv
// arm_mc_controller_if: instruction fields and flags into the multicycle
// controller, control selects and write strobes out to the datapath.
// master = datapath/instruction-register side, slave = controller side.
interface arm_mc_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control unit. Sequences
// fetch/decode/execute/memory/writeback, holds NZCV and evaluates Cond.
// Optional feature macro ARM_CTRL_CMP_EN: decode cmd 1010 (CMP) as a
// flag-only subtract that suppresses register/PC writeback.
module arm_mc_controller #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter logic [3:0] PC_REG      = 4'd15
) (
  input logic                clk,
  input logic                reset,
  arm_mc_controller_if.slave bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic [3:0] state_reg, state_next;
  logic [3:0] flags_reg;
  logic       condex_reg;
  logic       cond_true;
  logic [3:0] cmd;
  logic       is_exec, flag_we, pc_dest, no_writeback;
  logic [1:0] alu_control;
  logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign cmd     = bus.Funct[4:1];
  assign is_exec = (state_reg == S_EXECUTER) || (state_reg == S_EXECUTEI);
  assign pc_dest = (bus.Rd == PC_REG);
  assign flag_we = is_exec & condex_reg & bus.Funct[0];
  assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

`ifdef ARM_CTRL_CMP_EN
  assign no_writeback = (cmd == 4'b1010);
`else
  assign no_writeback = 1'b0;
`endif

  // Condition field evaluated against the stored (pre-update) flags
  always_comb begin
    cond_true = 1'b0;
    case (bus.Cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // ALU operation decode, active only in the execute states
  always_comb begin
    alu_control = 2'b00;
    if (is_exec) begin
      case (cmd)
        4'b0100: alu_control = 2'b00;
        4'b0010: alu_control = 2'b01;
        4'b0000: alu_control = 2'b10;
        4'b1100: alu_control = 2'b11;
`ifdef ARM_CTRL_CMP_EN
        4'b1010: alu_control = 2'b01;
`endif
        default: alu_control = 2'b00;
      endcase
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b01:   state_next = S_MEMADR;
          2'b00:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Per-state mux selects and raw (ungated) write strobes
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    case (state_reg)
      S_FETCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMRD:    adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = condex_reg;
        pc_write_raw  = condex_reg & pc_dest;
      end
      S_MEMWR: begin
        adr_src       = 1'b1;
        mem_write_raw = condex_reg;
      end
      S_EXECUTER: alu_src_b = 2'b00;
      S_EXECUTEI: alu_src_b = 2'b01;
      S_ALUWB: begin
        reg_write_raw = condex_reg & ~no_writeback;
        pc_write_raw  = condex_reg & pc_dest & ~no_writeback;
      end
      S_BRANCH: begin
        alu_src_b    = 2'b01;
        result_src   = 2'b10;
        pc_write_raw = condex_reg;
      end
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted instruction
  // cannot write anything, even though the FSM already sits in FETCH.
  assign bus.PCWrite    = pc_write_raw  & ~reset;
  assign bus.IRWrite    = ir_write_raw  & ~reset;
  assign bus.MemWrite   = mem_write_raw & ~reset;
  assign bus.RegWrite   = reg_write_raw & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.ALUControl = alu_control;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  // Latched condition result and NZCV flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg  <= FLAGS_RESET;
      condex_reg <= 1'b0;
    end else begin
      if (state_reg == S_DECODE) condex_reg <= cond_true;
      if (flag_we) begin
        flags_reg[3:2] <= bus.ALUFlags[3:2];
        // Logical ops leave C and V untouched
        if (!alu_control[1]) flags_reg[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

endmodule
